// File: rtl/seq_match_logger.sv
// rtl/seq_match_logger.sv - match-run logger behind the "11" sequence detector
//
// Samples det_in_i on every bit_valid_i slot, tracks runs of consecutive
// matches, counts runs and hits, and queues each finished run length in a
// small FIFO that a valid/ready reader drains.
//
// Ports:
//   clk          clock, all logic on posedge
//   reset        asynchronous, active-high
//   bit_valid_i  det_in_i is a valid detector sample this cycle
//   det_in_i     detector output (1 = "11" seen)
//   clr_i        synchronous clear of counters, FIFO and FSM
//   rd_ready_i   reader accepts the head entry
//   rd_valid_o   FIFO non-empty
//   rd_len_o     head entry run length (0 while empty)
//   run_count_o  number of 0->1 transitions of sampled det_in_i
//   hit_count_o  number of valid samples with det_in_i = 1
//   drop_count_o completed runs lost because the FIFO was full
//   fifo_full_o  FIFO holds DEPTH entries
module seq_match_logger #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bit_valid_i,
  input  logic             det_in_i,
  input  logic             clr_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [LEN_W-1:0] rd_len_o,
  output logic [CNT_W-1:0] run_count_o,
  output logic [CNT_W-1:0] hit_count_o,
  output logic [CNT_W-1:0] drop_count_o,
  output logic             fifo_full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]   OCC_FULL = DEPTH[PTR_W:0];
  localparam logic [PTR_W:0]   OCC_ONE  = 1;
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] cur_len_q, cur_len_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [LEN_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   occ_q;
  logic             push, pop, full, wr_en;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign full         = (occ_q == OCC_FULL);
  assign rd_valid_o   = (occ_q != '0);
  assign pop          = rd_valid_o & rd_ready_i;
  // Gate the head so stale storage never shows while the FIFO is empty.
  assign rd_len_o     = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign fifo_full_o  = full;
  assign run_count_o  = run_cnt_q;
  assign hit_count_o  = hit_cnt_q;
  assign drop_count_o = drop_cnt_q;

  always_comb begin
    state_d    = state_q;
    cur_len_d  = cur_len_q;
    run_cnt_d  = run_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    drop_cnt_d = drop_cnt_q;
    push       = 1'b0;
    if (bit_valid_i) begin
      case (state_q)
        IDLE: begin
          if (det_in_i) begin
            run_cnt_d = sat_inc(run_cnt_q);
            hit_cnt_d = sat_inc(hit_cnt_q);
            cur_len_d = LEN_W'(1);
            state_d   = RUN;
          end
        end
        RUN: begin
          if (det_in_i) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
            cur_len_d = cur_len_q + LEN_W'(cur_len_q != '1);
          end else begin
            push      = 1'b1;
            cur_len_d = '0;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    wr_en = push & (~full | pop);
    if (push & ~wr_en) drop_cnt_d = sat_inc(drop_cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cur_len_q  <= '0;
      run_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else if (clr_i) begin
      state_q    <= IDLE;
      cur_len_q  <= '0;
      run_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      drop_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      cur_len_q  <= cur_len_d;
      run_cnt_q  <= run_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (wr_en && !pop)      occ_q <= occ_q + OCC_ONE;
      else if (!wr_en && pop) occ_q <= occ_q - OCC_ONE;
    end
  end

  // Storage needs no reset: the pointers and occupancy define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= cur_len_q;
  end

endmodule
